// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: flush-to-zero inputs, guard/round/sticky
// alignment, one-bit-per-cycle normalisation and round-to-nearest-even.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic [EXP_W+MAN_W:0]   op1,
   input  logic [EXP_W+MAN_W:0]   op2,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   invalid
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int AW = MAN_W + 3;   // hidden + fraction + guard + round
   localparam int XW = MAN_W + 4;   // AW + sticky

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state;

   logic [W-1:0]   a_r, b_r;
   logic           sign_r, zsign_r, sub_r, nan_r, zero_r, flush_r;
   logic [EXP_W:0] exp_r;
   logic [XW-1:0]  ma_r, mb_r, sum_r;

   logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
   logic [MAN_W:0]   ma, mb, m_big, m_small;
   logic             swap, special, st;
   logic [2*AW-1:0]  wide;
   logic [AW-1:0]    sh;

   always_comb begin
      ea      = a_r[W-2:MAN_W];
      eb      = b_r[W-2:MAN_W];
      ma      = (ea == '0) ? '0 : {1'b1, a_r[MAN_W-1:0]};
      mb      = (eb == '0) ? '0 : {1'b1, b_r[MAN_W-1:0]};
      special = (&ea) | (&eb);
      swap    = {eb, mb} > {ea, ma};
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      m_big   = swap ? mb : ma;
      m_small = swap ? ma : mb;
      d       = e_big - e_small;
      // Bits falling off the low half of the double-width shift collapse into sticky.
      wide    = {m_small, 2'b00, {AW{1'b0}}} >> d;
      if (d >= EXP_W'(AW)) begin
         sh = '0;
         st = |m_small;
      end else begin
         sh = wide[2*AW-1:AW];
         st = |wide[AW-1:0];
      end
   end

   logic [XW:0] sum_w;

   always_comb begin
      sum_w = sub_r ? ({1'b0, ma_r} - {1'b0, mb_r})
                    : ({1'b0, ma_r} + {1'b0, mb_r});
   end

   logic [MAN_W:0]   mant;
   logic             rup;
   logic [MAN_W+1:0] rm;
   logic [EXP_W:0]   rexp;
   logic [MAN_W-1:0] rfrac;

   always_comb begin
      mant  = sum_r[XW-1:3];
      rup   = sum_r[2] & (sum_r[1] | sum_r[0] | mant[0]);
      rm    = {1'b0, mant} + (MAN_W+2)'(rup);
      rexp  = exp_r + (EXP_W+1)'(rm[MAN_W+1]);
      rfrac = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         sign_r    <= 1'b0;
         zsign_r   <= 1'b0;
         sub_r     <= 1'b0;
         nan_r     <= 1'b0;
         zero_r    <= 1'b0;
         flush_r   <= 1'b0;
         exp_r     <= '0;
         ma_r      <= '0;
         mb_r      <= '0;
         sum_r     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r     <= op1;
                  b_r     <= {op2[W-1] ^ op_sub, op2[W-2:0]};
                  nan_r   <= 1'b0;
                  zero_r  <= 1'b0;
                  flush_r <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ALIGN;
               end else begin
                  state   <= IDLE;
               end
            end
            ALIGN: begin
               sign_r  <= swap ? b_r[W-1] : a_r[W-1];
               zsign_r <= a_r[W-1] & b_r[W-1];
               sub_r   <= a_r[W-1] ^ b_r[W-1];
               exp_r   <= {1'b0, e_big};
               ma_r    <= {m_big, 3'b000};
               mb_r    <= {sh, st};
               nan_r   <= special;
               state   <= ADD;
            end
            ADD: begin
               // Special operands pass through here without touching the datapath.
               if (nan_r) begin
                  state <= ROUND;
               end else begin
                  if (sum_w[XW]) begin
                     sum_r <= {sum_w[XW:2], sum_w[1] | sum_w[0]};
                     exp_r <= exp_r + (EXP_W+1)'(1);
                  end else begin
                     sum_r <= sum_w[XW-1:0];
                  end
                  state <= NORM;
               end
            end
            NORM: begin
               if (sum_r == '0) begin
                  zero_r <= 1'b1;
                  state  <= ROUND;
               end else if (sum_r[XW-1]) begin
                  state  <= ROUND;
               end else if (exp_r <= (EXP_W+1)'(1)) begin
                  flush_r <= 1'b1;
                  state   <= ROUND;
               end else begin
                  sum_r <= {sum_r[XW-2:0], 1'b0};
                  exp_r <= exp_r - (EXP_W+1)'(1);
               end
            end
            ROUND: begin
               overflow  <= 1'b0;
               underflow <= 1'b0;
               invalid   <= 1'b0;
               if (nan_r) begin
                  result  <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                  invalid <= 1'b1;
               end else if (zero_r) begin
                  result  <= {zsign_r, {(W-1){1'b0}}};
               end else if (flush_r) begin
                  result    <= {sign_r, {(W-1){1'b0}}};
                  underflow <= 1'b1;
               end else if (rexp >= {1'b0, {EXP_W{1'b1}}}) begin
                  result   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  overflow <= 1'b1;
               end else begin
                  result <= {sign_r, rexp[EXP_W-1:0], rfrac};
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases plus random operations compared against an
// exact wide-integer model of single-precision add/sub with flush-to-zero and RNE.
module tb_fp_addsub_seq;
   logic        clk, rst, start, op_sub;
   logic [31:0] op1, op2, result;
   logic        busy, done, overflow, underflow, invalid;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
      .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result),
      .overflow(overflow), .underflow(underflow), .invalid(invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Exact reference: operands become integers on a common scale, summed, then rounded.
   task automatic model(input logic [31:0] x, input logic [31:0] y, input logic sub,
                        output logic [31:0] r, output logic [2:0] flags);
      logic [299:0] vx, vy, mag, top, rem, half;
      logic [23:0]  mx, my;
      logic         sx, sy, s;
      int           ex, ey, e0, p, be, shamt;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sx = x[31];
      sy = y[31] ^ sub;
      r = 32'h0;
      flags = 3'b000;
      if (ex == 255 || ey == 255) begin
         r = 32'h7FC00000;
         flags = 3'b001;
         return;
      end
      mx = (ex == 0) ? 24'h0 : {1'b1, x[22:0]};
      my = (ey == 0) ? 24'h0 : {1'b1, y[22:0]};
      if (mx == 0 && my == 0) begin
         r = {sx & sy, 31'h0};
         return;
      end
      if (mx == 0) e0 = ey;
      else if (my == 0) e0 = ex;
      else e0 = (ex < ey) ? ex : ey;
      vx = (mx == 0) ? 300'h0 : (300'(mx) << (ex - e0));
      vy = (my == 0) ? 300'h0 : (300'(my) << (ey - e0));
      if (sx == sy) begin
         mag = vx + vy; s = sx;
      end else if (vx >= vy) begin
         mag = vx - vy; s = sx;
      end else begin
         mag = vy - vx; s = sy;
      end
      if (mag == 0) begin
         r = 32'h0;
         return;
      end
      p = -1;
      for (int i = 299; i >= 0; i--) begin
         if (mag[i] && p < 0) p = i;
      end
      be = p + e0 - 23;
      if (be < 1) begin
         r = {s, 31'h0};
         flags = 3'b010;
         return;
      end
      if (p > 23) begin
         shamt = p - 23;
         top  = mag >> shamt;
         rem  = mag - (top << shamt);
         half = 300'(1) << (shamt - 1);
         if (rem > half || (rem == half && top[0])) top = top + 300'(1);
         if (top == (300'(1) << 24)) begin
            top = top >> 1;
            be++;
         end
      end else begin
         top = mag << (23 - p);
      end
      if (be >= 255) begin
         r = {s, 8'hFF, 23'h0};
         flags = 3'b100;
      end else begin
         r = {s, 8'(be), top[22:0]};
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen (or on timeout).
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output int lat);
      op1 = x; op2 = y; op_sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op1 = $urandom;
      op2 = $urandom;
      op_sub = 1'($urandom);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [31:0] er, input logic [2:0] ef,
                           input int elat);
      int lat;
      run_op(x, y, s, lat);
      check({tag, "_lat"}, 64'(lat), 64'(elat));
      check({tag, "_res"}, 64'(result), 64'(er));
      check({tag, "_flags"}, 64'({overflow, underflow, invalid}), 64'(ef));
   endtask

   initial begin
      int          lat, rsel, ex, ey, t;
      logic [31:0] x, y, er;
      logic [2:0]  ef;
      logic        s;

      rst = 1'b1; start = 1'b0; op_sub = 1'b0; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_result", 64'(result), 64'(0));
      check("reset_flags", 64'({overflow, underflow, invalid}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      directed("add_2p5_3p5", 32'h40200000, 32'h40600000, 1'b0, 32'h40C00000, 3'b000, 4);
      @(negedge clk);
      check("done_falls", 64'(done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("result_holds", 64'(result), 64'h40C00000);

      directed("cancel_add", 32'h40840000, 32'hC0800000, 1'b0, 32'h3E000000, 3'b000, 9);
      directed("cancel_sub", 32'h40840000, 32'h40800000, 1'b1, 32'h3E000000, 3'b000, 9);
      directed("x_minus_x", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4);
      directed("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 4);
      directed("above_tie", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000, 4);
      directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);
      directed("nan_in", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 3);
      directed("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 4);
      directed("mixed_zeros", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 4);
      directed("flush_uf", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 4);
      directed("denorm_ftz", 32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000, 4);

      // Reset while the cancellation is still normalising.
      @(negedge clk);
      op1 = 32'h40840000; op2 = 32'hC0800000; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_result", 64'(result), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      repeat (8) @(negedge clk);
      check("no_done_after_rst", 64'(done), 64'(0));
      directed("after_rst", 32'h40200000, 32'h40600000, 1'b0, 32'h40C00000, 3'b000, 4);

      // Random operations issued back-to-back in the DONE cycle.
      for (int n = 0; n < 250; n++) begin
         rsel = int'($urandom_range(0, 4));
         ex = (rsel == 0) ? int'($urandom_range(0, 5)) * 50 % 255 + 1 : int'($urandom_range(1, 254));
         if (rsel == 1) ex = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(250, 254));
         rsel = int'($urandom_range(0, 19));
         if (rsel == 0) ey = 0;
         else if (rsel == 1) ey = 255;
         else if (rsel < 10) begin
            t = ex + int'($urandom_range(0, 6)) - 3;
            ey = (t < 1) ? 1 : ((t > 254) ? 254 : t);
         end else if (rsel < 14) ey = ex;
         else ey = int'($urandom_range(1, 254));
         x = {1'($urandom), 8'(ex), 23'($urandom)};
         y = {1'($urandom), 8'(ey), 23'($urandom)};
         s = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            y = x; s = 1'b1;
         end
         model(x, y, s, er, ef);
         run_op(x, y, s, lat);
         check("rand_done", 64'(lat < 60), 64'(1));
         check("rand_res", {32'(n), result}, {32'(n), er});
         check("rand_flags", {32'(n), 29'h0, overflow, underflow, invalid}, {32'(n), 29'h0, ef});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
